gene_net_attractor: RTL and testbench

Parametrised attractor analyser for synchronous Boolean gene networks. It loads an N-gene initial state and iterates the network one step per clock. It finds the attractor with Brent's algorithm and reports the cycle length (λ), the transient length (μ), and whether the attractor is a fixed point or a cycle. It is the successor to the fixed 8-gene network, fixed-point checker and cycle checker, and replaces all three in one controller.

---
 rtl/gene_net_pkg.sv | 18 +
 rtl/gene_net_step.sv | 25 ++
 rtl/gene_net_attractor.sv | 192 +++++++++++++++++++
 tb/tb_gene_net_attractor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gene_net_pkg.sv
// Shared types and constants for the gene network attractor analyser.
// FSM state encoding, update-rule selectors and the default step budget.
package gene_net_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRENT,
        ST_LOAD,
        ST_ADV,
        ST_MU,
        ST_DONE
    } gn_state_e;

    localparam int RULE_ROTL         = 0;
    localparam int RULE_ANDL         = 1;
    localparam int DEFAULT_MAX_STEPS = 1024;

endpackage

// File: rtl/gene_net_step.sv
// One synchronous update of the Boolean gene network: y = f(x).
// Bit i sees its left neighbour x[i-1], with the index wrapping modulo N.
module gene_net_step
    import gene_net_pkg::*;
#(
    parameter int N    = 8,
    parameter int RULE = RULE_ROTL
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    logic [N-1:0] left_nb;

    assign left_nb = {x[N-2:0], x[N-1]};

    generate
        if (RULE == RULE_ANDL) begin : g_andl
            assign y = x & left_nb;
        end else begin : g_rotl
            assign y = left_nb;
        end
    endgenerate

endmodule

// File: rtl/gene_net_attractor.sv
// Brent cycle-finding controller: reports attractor length, transient length and entry state.
// Optional macro GENE_NET_STEPS_EN exposes the total step counter on port steps.
module gene_net_attractor
    import gene_net_pkg::*;
#(
    parameter int N         = 8,
    parameter int RULE      = RULE_ROTL,
    parameter int MAX_STEPS = DEFAULT_MAX_STEPS,
    parameter int CNT_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     x_in,
    output logic             busy,
    output logic             done,
    output logic             is_fixed,
    output logic             is_cycle,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_len,
    output logic [CNT_W-1:0] transient_len,
    output logic [N-1:0]     attractor_state,
`ifdef GENE_NET_STEPS_EN
    output logic [CNT_W-1:0] steps,
`endif
    output logic [N-1:0]     x_out
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    gn_state_e state, state_next;

    logic [N-1:0]     x0, tort, hare, tort_src, tort_f, hare_f;
    logic [CNT_W:0]   pow;
    logic [CNT_W-1:0] lam, lambda_r, k, mu, step_cnt;
    logic [CNT_W-1:0] cycle_len_r, transient_len_r;
    logic [N-1:0]     attractor_r;
    logic             timeout_r;
    logic             eq, at_max, accept, give_up;

    // In IDLE/DONE the tortoise stepper is borrowed to precompute f(x_in) for the start edge.
    assign tort_src = (state == ST_IDLE || state == ST_DONE) ? x_in : tort;

    gene_net_step #(.N(N), .RULE(RULE)) u_step_tort (.x(tort_src), .y(tort_f));
    gene_net_step #(.N(N), .RULE(RULE)) u_step_hare (.x(hare),     .y(hare_f));

    assign eq     = (tort == hare);
    assign at_max = (step_cnt == MAX_C);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        give_up    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_BRENT;
                end
            end
            ST_BRENT: begin
                if (eq) begin
                    state_next = ST_LOAD;
                end else if (at_max) begin
                    give_up    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_LOAD: state_next = ST_ADV;
            ST_ADV: begin
                if (at_max) begin
                    give_up    = 1'b1;
                    state_next = ST_DONE;
                end else if (k == CNT_W'(1)) begin
                    state_next = ST_MU;
                end
            end
            ST_MU: begin
                if (eq) begin
                    state_next = ST_DONE;
                end else if (at_max) begin
                    give_up    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0              <= '0;
            tort            <= '0;
            hare            <= '0;
            pow             <= '0;
            lam             <= '0;
            lambda_r        <= '0;
            k               <= '0;
            mu              <= '0;
            step_cnt        <= '0;
            cycle_len_r     <= '0;
            transient_len_r <= '0;
            attractor_r     <= '0;
            timeout_r       <= 1'b0;
        end else begin
            if (give_up) begin
                timeout_r <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        x0              <= x_in;
                        tort            <= x_in;
                        hare            <= tort_f;
                        pow             <= (CNT_W + 1)'(1);
                        lam             <= CNT_W'(1);
                        step_cnt        <= CNT_W'(1);
                        cycle_len_r     <= '0;
                        transient_len_r <= '0;
                        attractor_r     <= '0;
                        timeout_r       <= 1'b0;
                    end
                end
                ST_BRENT: begin
                    if (eq) begin
                        lambda_r <= lam;
                    end else if (!at_max) begin
                        // Power-of-two checkpoint: park the tortoise on the hare and restart lam.
                        if (pow == {1'b0, lam}) begin
                            tort <= hare;
                            pow  <= pow << 1;
                            lam  <= CNT_W'(1);
                        end else begin
                            lam  <= lam + CNT_W'(1);
                        end
                        hare     <= hare_f;
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    tort <= x0;
                    hare <= x0;
                    k    <= lambda_r;
                    mu   <= '0;
                end
                ST_ADV: begin
                    if (!at_max) begin
                        hare     <= hare_f;
                        k        <= k - CNT_W'(1);
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                ST_MU: begin
                    if (eq) begin
                        cycle_len_r     <= lambda_r;
                        transient_len_r <= mu;
                        attractor_r     <= tort;
                    end else if (!at_max) begin
                        tort     <= tort_f;
                        hare     <= hare_f;
                        mu       <= mu + CNT_W'(1);
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state == ST_BRENT) || (state == ST_LOAD) ||
                             (state == ST_ADV)   || (state == ST_MU);
    assign done            = (state == ST_DONE);
    assign timeout         = timeout_r;
    assign cycle_len       = cycle_len_r;
    assign transient_len   = transient_len_r;
    assign attractor_state = attractor_r;
    assign is_fixed        = (cycle_len_r == CNT_W'(1));
    assign is_cycle        = (cycle_len_r > CNT_W'(1));
    assign x_out           = hare;
`ifdef GENE_NET_STEPS_EN
    assign steps           = step_cnt;
`endif

endmodule

// File: tb/tb_gene_net_attractor.sv
// Directed bench for gene_net_attractor: three instances (ROTL, ANDL, ROTL with MAX_STEPS=4).
module tb_gene_net_attractor;
    import gene_net_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [7:0]  xin_v   [3];
    logic [2:0]  busy_v, done_v, fix_v, cyc_v, to_v;
    logic [10:0] cl_v    [3];
    logic [10:0] tl_v    [3];
    logic [7:0]  att_v   [3];
    logic [7:0]  xo_v    [3];
    logic [2:0]  cl2, tl2;
`ifdef GENE_NET_STEPS_EN
    logic [10:0] st0, st1;
    logic [2:0]  st2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign cl_v[2] = {8'b0, cl2};
    assign tl_v[2] = {8'b0, tl2};

    gene_net_attractor #(.N(8), .RULE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .x_in(xin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .is_fixed(fix_v[0]), .is_cycle(cyc_v[0]),
        .timeout(to_v[0]), .cycle_len(cl_v[0]), .transient_len(tl_v[0]),
        .attractor_state(att_v[0]),
`ifdef GENE_NET_STEPS_EN
        .steps(st0),
`endif
        .x_out(xo_v[0]));

    gene_net_attractor #(.N(8), .RULE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .x_in(xin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .is_fixed(fix_v[1]), .is_cycle(cyc_v[1]),
        .timeout(to_v[1]), .cycle_len(cl_v[1]), .transient_len(tl_v[1]),
        .attractor_state(att_v[1]),
`ifdef GENE_NET_STEPS_EN
        .steps(st1),
`endif
        .x_out(xo_v[1]));

    gene_net_attractor #(.N(8), .RULE(0), .MAX_STEPS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .x_in(xin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .is_fixed(fix_v[2]), .is_cycle(cyc_v[2]),
        .timeout(to_v[2]), .cycle_len(cl2), .transient_len(tl2),
        .attractor_state(att_v[2]),
`ifdef GENE_NET_STEPS_EN
        .steps(st2),
`endif
        .x_out(xo_v[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int d, input logic [7:0] x);
        @(negedge clk);
        start_v[d] = 1'b1;
        xin_v[d]   = x;
        @(negedge clk);
        start_v[d] = 1'b0;
        xin_v[d]   = 8'h00;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n = 0;
        while (done_v[d] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".done"}, done_v[d], 1);
        chk({tag, ".busy"}, busy_v[d], 0);
    endtask

    task automatic res(input int d, input string tag, input logic f, input logic c,
                       input logic to, input logic [10:0] cl, input logic [10:0] tl,
                       input logic [7:0] at);
        chk({tag, ".is_fixed"}, fix_v[d], f);
        chk({tag, ".is_cycle"}, cyc_v[d], c);
        chk({tag, ".timeout"}, to_v[d], to);
        chk({tag, ".cycle_len"}, cl_v[d], cl);
        chk({tag, ".transient_len"}, tl_v[d], tl);
        chk({tag, ".attractor"}, att_v[d], at);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < 3; i++) xin_v[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy_v, 3'b000);
        chk("rst.done", done_v, 3'b000);
        chk("rst.x_out", xo_v[0], 8'h00);
        res(0, "rst", 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'h00);
        rst = 1'b0;

        // ROTL 0x01 with an ignored start pulse (x_in=0x11) while in BRENT
        go(0, 8'h01);
        chk("rotl01.busy_rise", busy_v[0], 1);
        start_v[0] = 1'b1;
        xin_v[0]   = 8'h11;
        @(negedge clk);
        start_v[0] = 1'b0;
        xin_v[0]   = 8'h00;
        chk("ignored_start.busy", busy_v[0], 1);
        wait_done(0, "rotl01");
        res(0, "rotl01", 1'b0, 1'b1, 1'b0, 11'd8, 11'd0, 8'h01);

        go(0, 8'h11);
        wait_done(0, "rotl11");
        res(0, "rotl11", 1'b0, 1'b1, 1'b0, 11'd4, 11'd0, 8'h11);

        // back-to-back restart from DONE
        start_v[0] = 1'b1;
        xin_v[0]   = 8'h55;
        @(negedge clk);
        start_v[0] = 1'b0;
        xin_v[0]   = 8'h00;
        chk("b2b.busy", busy_v[0], 1);
        chk("b2b.done", done_v[0], 0);
        chk("b2b.cleared_len", cl_v[0], 11'd0);
        wait_done(0, "rotl55");
        res(0, "rotl55", 1'b0, 1'b1, 1'b0, 11'd2, 11'd0, 8'h55);

        go(1, 8'h00);
        wait_done(1, "andl00");
        res(1, "andl00", 1'b1, 1'b0, 1'b0, 11'd1, 11'd0, 8'h00);

        go(1, 8'h07);
        wait_done(1, "andl07");
        res(1, "andl07", 1'b1, 1'b0, 1'b0, 11'd1, 11'd3, 8'h00);
        chk("andl07.x_out", xo_v[1], 8'h00);

        go(2, 8'h01);
        wait_done(2, "timeout");
        res(2, "timeout", 1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 8'h00);

        // asynchronous reset in the middle of ADV
        go(0, 8'h01);
        n = 0;
        while (dut0.state !== ST_ADV && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_adv", (dut0.state === ST_ADV), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.busy", busy_v[0], 0);
        chk("arst.done", done_v[0], 0);
        chk("arst.x_out", xo_v[0], 8'h00);
        chk("arst.state", (dut0.state === ST_IDLE), 1);
        res(0, "arst", 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        go(0, 8'hFF);
        wait_done(0, "rotlFF");
        res(0, "rotlFF", 1'b1, 1'b0, 1'b0, 11'd1, 11'd0, 8'hFF);
        chk("rotlFF.x_out", xo_v[0], 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
